// File: rtl/addsub_seq_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
package addsub_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_nibble.sv
// 4-bit ripple add/subtract slice with an explicit carry-in so slices can chain.
// m=1 inverts b; the caller supplies cin=1 on the first nibble of a subtract.
// Optional c3 output (carry into bit 3) exists only with ADDSUB_SEQ_OVERFLOW_EN.
module addsub_nibble
  import addsub_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                m,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  ,
  output logic                c3
`endif
);

  logic [NIBBLE_W-1:0] b_x;
  logic [NIBBLE_W:0]   c;

  // Ripple chain over the four bits.
  always_comb begin
    b_x  = b ^ {NIBBLE_W{m}};
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b_x[i] ^ c[i];
      c[i+1] = (a[i] & b_x[i]) | (a[i] & c[i]) | (b_x[i] & c[i]);
    end
    cout = c[NIBBLE_W];
  end

`ifdef ADDSUB_SEQ_OVERFLOW_EN
  assign c3 = c[NIBBLE_W-1];
`endif

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial multi-word add/subtract controller: one addsub_nibble slice,
// one nibble per clock, LSB first, carry/borrow held in a register.
// NIBBLES legal range is 2..8. Define ADDSUB_SEQ_OVERFLOW_EN to add the
// signed-overflow output.
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         op,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  result,
  output logic                         carry_out
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  ,
  output logic                         overflow
`endif
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e              state;
  logic [IDX_W-1:0]    idx;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                op_q;
  logic                carry_q;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                cout_nib;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  logic                c3_nib;
`endif

  // Select the current nibble of the latched operands.
  always_comb begin
    a_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
    b_nib = b_q[idx*NIBBLE_W +: NIBBLE_W];
  end

  // The slice applies the b inversion itself from op_q.
  addsub_nibble u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .m    (op_q),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (cout_nib)
`ifdef ADDSUB_SEQ_OVERFLOW_EN
    ,
    .c3   (c3_nib)
`endif
  );

  // Status flags decode straight from the registered state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Sequencer FSM with operand latch, carry register and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            // Subtract is a + ~b + 1: seed the chain with op.
            carry_q <= op;
            idx     <= '0;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          result[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
          carry_q <= cout_nib;
          if (idx == LAST_IDX) begin
            carry_out <= cout_nib;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
            overflow  <= c3_nib ^ cout_nib;
`endif
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl (NIBBLES=4). Overflow checks are
// compiled in when ADDSUB_SEQ_OVERFLOW_EN is defined.
module tb_addsub_seq_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  logic         overflow;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef ADDSUB_SEQ_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected response.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1, expected no done (result=%0h)", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("carry_out", 32'(carry_out), 32'(e.c));
`ifdef ADDSUB_SEQ_OVERFLOW_EN
        chk("overflow", 32'(overflow), 32'(e.v));
`endif
      end
    end
  end

  // Present one request for a single clock edge and queue its expected response.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    op    = top;
    start = 1'b1;
    sbq.push_back('{r: er, c: ec, v: ev});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for done after issue(); checks latency and that busy covers the run.
  task automatic wait_done(input string nm);
    int lat  = 0;
    int bcnt = 0;
    bit seen = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      lat++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected done", nm, lat);
    end else begin
      chk({nm, "_latency"}, 32'(lat), 32'(NIB));
      chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(NIB));
    end
  endtask

  initial begin
    int n;
    bit seen;
    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_carry", 32'(carry_out), 32'h0);
    rst = 1'b0;

    // Basic add and subtract vectors.
    issue(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0); wait_done("add1");
    issue(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0); wait_done("sub_borrow");
    issue(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0); wait_done("sub_noborrow");
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); wait_done("add_wrap");
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1); wait_done("add_ovf");
    issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1); wait_done("sub_ovf");

    // Start during RUN is ignored; start in DONE is accepted back-to-back.
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("b2b_first_done_seen", 32'(seen), 32'h1);
    a = 16'h0010; b = 16'h0001; op = 1'b1; start = 1'b1;
    sbq.push_back('{r: 16'h000F, c: 1'b1, v: 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    chk("b2b_spacing", 32'(n), 32'd5);

    // Asynchronous reset mid-run at nibble index 2.
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("partial_result", 32'(result), 32'h0045);
    rst = 1'b1;
    #1;
    void'(sbq.pop_back());
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_carry", 32'(carry_out), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(16'hABCD, 16'h0001, 1'b0, 16'hABCE, 1'b0, 1'b0); wait_done("after_rst");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
